// File: rtl/duty_meas_scheduler_if.sv
// Result channel of duty_meas_scheduler: one measurement record per transfer.
interface duty_meas_scheduler_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 32
);
    // A record transfers on a cycle where res_valid && res_ready. Once raised,
    // res_valid and every res_* field stay stable until that cycle; res_ready
    // may be driven freely and never depends on res_valid combinationally.
    logic             res_valid;
    logic             res_ready;
    logic [CH_W-1:0]  res_ch;
    logic [CNT_W-1:0] res_high;
    logic [CNT_W-1:0] res_low;
    logic [9:0]       res_duty;
    logic             res_timeout;

    modport master (
        output res_valid, res_ch, res_high, res_low, res_duty, res_timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_ch, res_high, res_low, res_duty, res_timeout,
        output res_ready
    );
endinterface

// File: rtl/duty_meas_scheduler.sv
// Time-multiplexed duty-cycle meter: one shared counter set and serial divider.
// Define DUTY_AUTO_RESCAN_EN to rescan continuously from ch_mask without start.
module duty_meas_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int AVG_PERIODS = 4,
    parameter int TIMEOUT     = 1000000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [NUM_CH-1:0]     signal_in,
    output logic                  busy,
    output logic [2:0]            dbg_state,
    duty_meas_scheduler_if.master res
);
    localparam int DW  = CNT_W + 10;
    localparam int DCW = $clog2(DW);
    localparam int PW  = (AVG_PERIODS > 1) ? $clog2(AVG_PERIODS) : 1;
    localparam logic [DW-1:0] K1000 = DW'(1000);

    typedef enum logic [2:0] {
        IDLE, SELECT, ARM, MEAS_HIGH, MEAS_LOW, DIVIDE, REPORT
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] sync1, sync2, pending;
    logic [CH_W-1:0]   cur_ch;
    logic              prev_s, sel_cnt;
    logic [PW-1:0]     pcnt;
    logic [CNT_W-1:0]  sum_high, sum_low, tmo_cnt, divisor;
    logic [DW-1:0]     dvd;
    logic [CNT_W:0]    rem, rem_sh;
    logic [DCW-1:0]    div_cnt;
    logic              sample, rise, fall, q_bit, tmo_hit;
    logic [NUM_CH-1:0] scan_src, next_pending;
    logic [CH_W-1:0]   next_ch;

    function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
        lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) lowest = CH_W'(i);
    endfunction

    always_comb begin
        sample  = sync2[cur_ch];
        rise    = sample & ~prev_s;
        fall    = ~sample & prev_s;
        divisor = sum_high + sum_low;
        rem_sh  = {rem[CNT_W-1:0], dvd[DW-1]};
        q_bit   = (rem_sh >= {1'b0, divisor});
        tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
        // Remaining channels first; the live mask only seeds a new scan.
        scan_src     = (state == REPORT && pending != '0) ? pending : ch_mask;
        next_ch      = lowest(scan_src);
        next_pending = scan_src & (scan_src - NUM_CH'(1));
    end

    assign dbg_state = state;

`ifdef DUTY_AUTO_RESCAN_EN
    logic unused_start;
    assign unused_start = start;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            sync1    <= '0;
            sync2    <= '0;
            pending  <= '0;
            cur_ch   <= '0;
            prev_s   <= 1'b0;
            sel_cnt  <= 1'b0;
            pcnt     <= '0;
            sum_high <= '0;
            sum_low  <= '0;
            tmo_cnt  <= '0;
            dvd      <= '0;
            rem      <= '0;
            div_cnt  <= '0;
            res.res_valid   <= 1'b0;
            res.res_ch      <= '0;
            res.res_high    <= '0;
            res.res_low     <= '0;
            res.res_duty    <= '0;
            res.res_timeout <= 1'b0;
        end else begin
            sync1  <= signal_in;
            sync2  <= sync1;
            prev_s <= sample;
            case (state)
                IDLE: begin
`ifdef DUTY_AUTO_RESCAN_EN
                    if (ch_mask != '0) begin
                        busy    <= 1'b1;
                        cur_ch  <= next_ch;
                        pending <= next_pending;
                        sel_cnt <= 1'b0;
                        state   <= SELECT;
                    end
`else
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        busy <= 1'b1;
                        if (ch_mask != '0) begin
                            cur_ch  <= next_ch;
                            pending <= next_pending;
                            sel_cnt <= 1'b0;
                            state   <= SELECT;
                        end
                    end
`endif
                end
                SELECT: begin
                    sel_cnt  <= 1'b1;
                    sum_high <= '0;
                    sum_low  <= '0;
                    pcnt     <= '0;
                    tmo_cnt  <= '0;
                    if (sel_cnt) state <= ARM;
                end
                ARM, MEAS_HIGH, MEAS_LOW: begin
                    tmo_cnt <= (rise || fall) ? '0 : tmo_cnt + CNT_W'(1);
                    if (!(rise || fall) && tmo_hit) begin
                        res.res_valid   <= 1'b1;
                        res.res_ch      <= cur_ch;
                        res.res_high    <= '0;
                        res.res_low     <= '0;
                        res.res_duty    <= sample ? 10'd1000 : 10'd0;
                        res.res_timeout <= 1'b1;
                        state           <= REPORT;
                    end else if (state == ARM) begin
                        if (rise) begin
                            sum_high <= CNT_W'(1);
                            state    <= MEAS_HIGH;
                        end
                    end else if (state == MEAS_HIGH) begin
                        if (fall) begin
                            sum_low <= sum_low + CNT_W'(1);
                            state   <= MEAS_LOW;
                        end else if (sample) begin
                            sum_high <= sum_high + CNT_W'(1);
                        end
                    end else begin
                        if (rise) begin
                            if (pcnt == PW'(AVG_PERIODS - 1)) begin
                                dvd     <= DW'(sum_high) * K1000;
                                rem     <= '0;
                                div_cnt <= '0;
                                state   <= DIVIDE;
                            end else begin
                                pcnt     <= pcnt + PW'(1);
                                sum_high <= sum_high + CNT_W'(1);
                                state    <= MEAS_HIGH;
                            end
                        end else if (!sample) begin
                            sum_low <= sum_low + CNT_W'(1);
                        end
                    end
                end
                DIVIDE: begin
                    // Restoring division; quotient bits shift into dvd's LSB.
                    dvd     <= {dvd[DW-2:0], q_bit};
                    rem     <= q_bit ? rem_sh - {1'b0, divisor} : rem_sh;
                    div_cnt <= div_cnt + DCW'(1);
                    if (div_cnt == DCW'(DW - 1)) begin
                        res.res_valid   <= 1'b1;
                        res.res_ch      <= cur_ch;
                        res.res_high    <= sum_high;
                        res.res_low     <= sum_low;
                        res.res_duty    <= {dvd[8:0], q_bit};
                        res.res_timeout <= 1'b0;
                        state           <= REPORT;
                    end
                end
                REPORT: begin
                    if (res.res_ready) begin
                        res.res_valid <= 1'b0;
`ifdef DUTY_AUTO_RESCAN_EN
                        if (scan_src != '0) begin
`else
                        if (pending != '0) begin
`endif
                            cur_ch  <= next_ch;
                            pending <= next_pending;
                            sel_cnt <= 1'b0;
                            state   <= SELECT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_duty_meas_scheduler.sv
// Directed bench for duty_meas_scheduler: stimulus pushes expected records,
// a monitor pops and compares on every result handshake.
module tb_duty_meas_scheduler;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [9:0]  duty;
    logic        tmo;
  } res_t;
  localparam int RW = $bits(res_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [NUM_CH-1:0] signal_in = '0;
  logic busy;
  logic [2:0] dbg_state;

  duty_meas_scheduler_if #(.CH_W(2), .CNT_W(CNT_W)) res_if ();

  duty_meas_scheduler #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .AVG_PERIODS(4), .TIMEOUT(1000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask),
    .signal_in(signal_in), .busy(busy), .dbg_state(dbg_state), .res(res_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];

  // per-channel waveform generator: hi_len==0 -> stuck low, lo_len==0 -> stuck high
  int hi_len[NUM_CH];
  int lo_len[NUM_CH];
  int ph[NUM_CH];
  int stall_en = 0;
  int stall_cnt = 0;

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin hi_len[c] = 0; lo_len[c] = 0; ph[c] = 0; end
    forever begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
        if (hi_len[c] == 0) signal_in[c] = 1'b0;
        else if (lo_len[c] == 0) signal_in[c] = 1'b1;
        else begin
          ph[c] = (ph[c] + 1) % (hi_len[c] + lo_len[c]);
          signal_in[c] = (ph[c] < hi_len[c]);
        end
      end
    end
  end

  // consumer: always ready, or hold off 50 cycles per result when stalling
  initial begin
    res_if.res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_en == 0) res_if.res_ready = 1'b1;
      else if (res_if.res_valid && !res_if.res_ready) begin
        stall_cnt++;
        if (stall_cnt >= 50) res_if.res_ready = 1'b1;
      end else if (res_if.res_ready) begin
        res_if.res_ready = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int hi, input int lo, input int duty, input bit tmo);
    res_t r;
    r.ch = 2'(ch); r.hi = 32'(hi); r.lo = 32'(lo); r.duty = 10'(duty); r.tmo = tmo;
    exp_q.push_back(r);
  endtask

  task automatic do_start(input logic [NUM_CH-1:0] m);
    @(posedge clk); #1;
    ch_mask = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: %0d results outstanding after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_valid"}, 64'(res_if.res_valid), 0);
    check({tag, "_ch"}, 64'(res_if.res_ch), 0);
    check({tag, "_high"}, 64'(res_if.res_high), 0);
    check({tag, "_low"}, 64'(res_if.res_low), 0);
    check({tag, "_duty"}, 64'(res_if.res_duty), 0);
    check({tag, "_tmo"}, 64'(res_if.res_timeout), 0);
    check({tag, "_state"}, 64'(dbg_state), 0);
  endtask

  // scoreboard monitor
  res_t held;
  int   hold_cycles = 0;
  always @(negedge clk) begin
    res_t cur, e;
    if (rst) hold_cycles = 0;
    else if (res_if.res_valid) begin
      cur = {res_if.res_ch, res_if.res_high, res_if.res_low, res_if.res_duty, res_if.res_timeout};
      if (hold_cycles == 0) held = cur;
      else check("hold_stable", 64'(cur != held), 0);
      hold_cycles++;
      if (res_if.res_ready) begin
        hold_cycles = 0;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result: ch=%0d duty=%0d, required no result", cur.ch, cur.duty);
        end else begin
          e = exp_q.pop_front();
          check("res_ch", 64'(cur.ch), 64'(e.ch));
          check("res_high", 64'(cur.hi), 64'(e.hi));
          check("res_low", 64'(cur.lo), 64'(e.lo));
          check("res_duty", 64'(cur.duty), 64'(e.duty));
          check("res_timeout", 64'(cur.tmo), 64'(e.tmo));
        end
      end
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded 60000 cycles, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

`ifdef DUTY_AUTO_RESCAN_EN
    // continuous rescan: 3 high / 1 low -> 12/4, 750 permille
    hi_len[0] = 3; lo_len[0] = 1; ph[0] = 0;
    repeat (3) push_exp(0, 12, 4, 750, 1'b0);
    @(posedge clk); #1 ch_mask = 4'b0001;
    n = 0;
    while (exp_q.size() > 1 && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk); #1 ch_mask = 4'b0000;
    wait_done(2000);
    check("rescan_stop_busy", 64'(busy), 0);
    repeat (200) @(negedge clk);
    check("rescan_stopped_valid", 64'(res_if.res_valid), 0);
    check("rescan_stopped_state", 64'(dbg_state), 0);
`else
    // single channel, 3 high / 7 low
    hi_len[0] = 3; lo_len[0] = 7; ph[0] = 0;
    push_exp(0, 12, 28, 300, 1'b0);
    do_start(4'b0001);
    wait_done(2000);
    check("scan1_busy_end", 64'(busy), 0);

    // floor of 4000/12
    hi_len[0] = 1; lo_len[0] = 2; ph[0] = 0;
    push_exp(0, 4, 8, 333, 1'b0);
    do_start(4'b0001);
    wait_done(2000);

    // stuck high then stuck low on ch1
    hi_len[1] = 5; lo_len[1] = 0;
    repeat (5) @(posedge clk);
    push_exp(1, 0, 0, 1000, 1'b1);
    do_start(4'b0010);
    wait_done(3000);
    hi_len[1] = 0; lo_len[1] = 0;
    repeat (5) @(posedge clk);
    push_exp(1, 0, 0, 0, 1'b1);
    do_start(4'b0010);
    wait_done(3000);

    // two channels, stalled consumer, stray starts and mask changes mid-scan
    hi_len[1] = 2; lo_len[1] = 6; ph[1] = 0;
    hi_len[3] = 5; lo_len[3] = 3; ph[3] = 0;
    stall_en = 1;
    repeat (3) @(posedge clk);
    push_exp(1, 8, 24, 250, 1'b0);
    push_exp(3, 20, 12, 625, 1'b0);
    do_start(4'b1010);
    fork
      wait_done(5000);
      begin
        for (int k = 0; k < 3; k++) begin
          repeat (40) @(posedge clk);
          #1 ch_mask = 4'b1111; start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
        end
      end
    join
    check("scan2_busy_end", 64'(busy), 0);
    stall_en = 0;
    repeat (5) @(posedge clk);

    // reset during MEAS_LOW aborts with no result
    hi_len[0] = 3; lo_len[0] = 7; ph[0] = 0;
    do_start(4'b0001);
    n = 0;
    while (dbg_state != 3'd4 && n < 500) begin @(negedge clk); n++; end
    check("reach_meas_low", 64'(dbg_state), 4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    push_exp(0, 12, 28, 300, 1'b0);
    do_start(4'b0001);
    wait_done(2000);

    // empty mask: one-cycle busy, no result
    do_start(4'b0000);
    @(negedge clk);
    check("empty_busy_pulse", 64'(busy), 1);
    @(negedge clk);
    check("empty_busy_drop", 64'(busy), 0);
    repeat (50) @(negedge clk);
    check("empty_no_valid", 64'(res_if.res_valid), 0);
`endif

    check("queue_drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
